fifo_downsize: RTL and testbench

Parametrised width-down-converting FIFO. Each write accepts one IN_WIDTH word; reads return RATIO OUT_WIDTH slices per stored word, least-significant slice first. It is the generalised successor of the fixed 128x8-in/4-out buffer in the SDR sample path. It adds configurable ratio and depth, word count, an almost-full flag and deterministic output when empty.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_mem_1r1w.sv | 22 ++
 rtl/fifo_downsize.sv | 111 +++++++++++
 tb/tb_fifo_downsize.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the width-down-converting FIFO: derived widths and
// parameter legality checks.
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int out_width(input int in_w, input int ratio);
    return in_w / ratio;
  endfunction

  function automatic int count_width(input int depth_bits);
    return depth_bits + 1;
  endfunction

  // Slice selector needs at least one bit even when RATIO is 1.
  function automatic int sel_width(input int ratio);
    return (ratio > 1) ? clog2(ratio) : 1;
  endfunction

  function automatic bit params_ok(input int in_w, input int ratio, input int depth,
                                   input int depth_bits, input int afull_level);
    return (ratio >= 1) && (in_w % ratio == 0) && (depth == (1 << depth_bits)) &&
           (afull_level >= 1) && (afull_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// Register-array storage: synchronous write, asynchronous read.
module fifo_mem_1r1w #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_downsize.sv
// Width-down-converting FIFO: one IN_WIDTH word per write, RATIO slices per read
// word, LS slice first. Optional sticky OVF/UDF flags under FIFO_ERR_FLAGS_EN.
module fifo_downsize
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int RATIO       = 2,
  parameter int DEPTH       = 128,
  parameter int DEPTH_BITS  = 7,
  parameter int AFULL_LEVEL = 96
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic [IN_WIDTH-1:0]                  DATA,
  input  logic                                 WE,
  input  logic                                 RE,
  output logic [out_width(IN_WIDTH,RATIO)-1:0] Q,
  output logic                                 FULL,
  output logic                                 EMPTY,
  output logic                                 AFULL,
  output logic [DEPTH_BITS:0]                  COUNT,
  output logic                                 OVF,
  output logic                                 UDF
);

  localparam int OUT_WIDTH = out_width(IN_WIDTH, RATIO);
  localparam int CW        = count_width(DEPTH_BITS);
  localparam int SW        = sel_width(RATIO);

  generate
    if (!params_ok(IN_WIDTH, RATIO, DEPTH, DEPTH_BITS, AFULL_LEVEL)) begin : g_bad_params
      $error("fifo_downsize: illegal parameter combination");
    end
  endgenerate

  logic [DEPTH_BITS-1:0]             head, tail;
  logic [SW-1:0]                     sel;
  logic [CW-1:0]                     count;
  logic [IN_WIDTH-1:0]               rd_word;
  logic [RATIO-1:0][OUT_WIDTH-1:0]   slices;
  logic                              wr_ok, rd_ok, last_slice, pop;

  // Flags come from the registered count only, so a pop does not free a
  // slot for a write in the same cycle.
  assign FULL  = (count == CW'(DEPTH));
  assign EMPTY = (count == '0);
  assign AFULL = (count >= CW'(AFULL_LEVEL));
  assign COUNT = count;

  assign wr_ok      = WE & ~FULL;
  assign rd_ok      = RE & ~EMPTY;
  assign last_slice = (sel == SW'(RATIO - 1));
  assign pop        = rd_ok & last_slice;

  fifo_mem_1r1w #(.WIDTH(IN_WIDTH), .DEPTH(DEPTH), .ADDR_W(DEPTH_BITS)) u_mem (
    .clk   (CLK),
    .we    (wr_ok),
    .waddr (head),
    .wdata (DATA),
    .raddr (tail),
    .rdata (rd_word)
  );

  assign slices = rd_word;
  assign Q      = EMPTY ? '0 : slices[sel];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head  <= '0;
      tail  <= '0;
      sel   <= '0;
      count <= '0;
    end else begin
      if (wr_ok) head <= head + 1'b1;
      if (rd_ok) begin
        if (last_slice) begin
          sel  <= '0;
          tail <= tail + 1'b1;
        end else begin
          sel <= sel + 1'b1;
        end
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (WE & FULL)  ovf_q <= 1'b1;
      if (RE & EMPTY) udf_q <= 1'b1;
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`else
  assign OVF = 1'b0;
  assign UDF = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_downsize.sv
// Directed bench for fifo_downsize: default 8->4 instance plus a 16->4, depth-16 instance.
module tb_fifo_downsize;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0, re = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] q;
  logic       full, empty, afull, ovf, udf;
  logic [7:0] count;

  logic        we_b = 1'b0, re_b = 1'b0;
  logic [15:0] data_b = '0;
  logic [3:0]  q_b;
  logic        full_b, empty_b, afull_b, ovf_b, udf_b;
  logic [4:0]  count_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fifo_downsize dut (
    .CLK(CLK), .RESET(rst), .DATA(data), .WE(we), .RE(re), .Q(q),
    .FULL(full), .EMPTY(empty), .AFULL(afull), .COUNT(count), .OVF(ovf), .UDF(udf)
  );

  fifo_downsize #(.IN_WIDTH(16), .RATIO(4), .DEPTH(16), .DEPTH_BITS(4), .AFULL_LEVEL(12)) dut_b (
    .CLK(CLK), .RESET(rst), .DATA(data_b), .WE(we_b), .RE(re_b), .Q(q_b),
    .FULL(full_b), .EMPTY(empty_b), .AFULL(afull_b), .COUNT(count_b), .OVF(ovf_b), .UDF(udf_b)
  );

  typedef struct packed {
    logic       rst;
    logic       we;
    logic       re;
    logic [7:0] data;
    logic [3:0] eq;
    logic       eempty;
    logic [7:0] ecount;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; we_b = 1'b0; re_b = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] bword(input int i);
    return 16'(i * 16'h1357 + 16'h2468);
  endfunction

  logic [3:0]  nib_q [$];
  logic [7:0]  w8;
  logic [15:0] w16;

  initial begin
    // Single-word round trip, then a reset that discards a part-read word.
    vt[0]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 4'h5, 1'b0, 8'd1};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'hA, 1'b0, 8'd1};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 1'b1, 8'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 8'h21, 4'h1, 1'b0, 8'd1};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 8'h43, 4'h1, 1'b0, 8'd2};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 8'h65, 4'h1, 1'b0, 8'd3};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h2, 1'b0, 8'd3};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 8'h77, 4'h0, 1'b1, 8'd0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 4'hC, 1'b0, 8'd1};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h3, 1'b0, 8'd1};
    vt[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 1'b1, 8'd0};

    tick();
    do_reset();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_count", count, 0);
    chk("rst_q", q, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);

    for (int i = 0; i < 11; i++) begin
      rst = vt[i].rst; we = vt[i].we; re = vt[i].re; data = vt[i].data;
      tick();
      chk($sformatf("vec%0d_q", i), q, vt[i].eq);
      chk($sformatf("vec%0d_empty", i), empty, vt[i].eempty);
      chk($sformatf("vec%0d_count", i), count, vt[i].ecount);
    end
    rst = 1'b0; we = 1'b0; re = 1'b0;

    // Underflow flag and stickiness.
    re = 1'b1; tick(); re = 1'b0;
    chk("udf_set", udf, EXP_ERR);
    chk("udf_empty_count", count, 0);
    tick();
    chk("udf_held", udf, EXP_ERR);

    // Fill to full, reject extra write, drain every slice in order.
    for (int i = 0; i < 128; i++) begin
      we = 1'b1; data = 8'(i);
      tick();
      chk($sformatf("fill%0d_count", i), count, i + 1);
      chk($sformatf("fill%0d_afull", i), afull, (i + 1) >= 96);
      chk($sformatf("fill%0d_full", i), full, (i + 1) == 128);
    end
    data = 8'hFF; tick(); we = 1'b0;
    chk("ovf_write_count", count, 128);
    chk("ovf_set", ovf, EXP_ERR);
    chk("full_not_empty", empty, 0);
    for (int k = 0; k < 256; k++) begin
      w8 = 8'(k / 2);
      chk($sformatf("drain%0d_q", k), q, (k % 2) ? w8[7:4] : w8[3:0]);
      re = 1'b1; tick();
    end
    re = 1'b0;
    chk("drained_empty", empty, 1);
    chk("drained_count", count, 0);
    chk("drained_q", q, 0);
    chk("udf_after_drain", udf, EXP_ERR);
    do_reset();
    chk("rst_clr_ovf", ovf, 0);
    chk("rst_clr_udf", udf, 0);

    // Streaming through pointer wrap: one write per popped word keeps count at 3.
    nib_q.delete();
    for (int i = 0; i < 3; i++) begin
      w8 = 8'(i * 37 + 11);
      we = 1'b1; data = w8; nib_q.push_back(w8[3:0]); nib_q.push_back(w8[7:4]);
      tick();
    end
    we = 1'b0;
    for (int c = 0; c < 300; c++) begin
      chk($sformatf("stream%0d_q", c), q, nib_q.pop_front());
      re = 1'b1;
      we = (c % 2) == 1;
      if (we) begin
        w8 = 8'((c + 3) * 37 + 11);
        data = w8; nib_q.push_back(w8[3:0]); nib_q.push_back(w8[7:4]);
      end
      tick();
      chk($sformatf("stream%0d_count", c), count, (c % 2) ? 3 : 3);
      chk($sformatf("stream%0d_flags", c), {full, empty}, 2'b00);
    end
    re = 1'b0; we = 1'b0;
    do_reset();

    // Last slice popped while full: same-cycle write rejected, next accepted.
    for (int i = 0; i < 128; i++) begin
      we = 1'b1; data = 8'(i); tick();
    end
    we = 1'b0; re = 1'b1; tick();
    chk("fullpop_s0_count", count, 128);
    we = 1'b1; data = 8'hEE; tick();
    chk("fullpop_count", count, 127);
    chk("fullpop_full", full, 0);
    re = 1'b0; tick(); we = 1'b0;
    chk("fullpop_next_count", count, 128);
    chk("fullpop_next_full", full, 1);
    chk("fullpop_q", q, 4'h1);
    do_reset();

    // 16-bit, ratio-4, depth-16 instance.
    we_b = 1'b1; data_b = 16'hBEEF; tick(); we_b = 1'b0;
    chk("b_first_q", q_b, 4'hF);
    chk("b_first_count", count_b, 1);
    re_b = 1'b1;
    tick(); chk("b_s1", q_b, 4'hE);
    tick(); chk("b_s2", q_b, 4'hE);
    tick(); chk("b_s3", q_b, 4'hB);
    chk("b_s3_count", count_b, 1);
    tick(); re_b = 1'b0;
    chk("b_end_q", q_b, 0);
    chk("b_end_empty", empty_b, 1);
    for (int i = 0; i < 16; i++) begin
      we_b = 1'b1; data_b = bword(i);
      tick();
      chk($sformatf("b_fill%0d_count", i), count_b, i + 1);
      chk($sformatf("b_fill%0d_afull", i), afull_b, (i + 1) >= 12);
      chk($sformatf("b_fill%0d_full", i), full_b, (i + 1) == 16);
    end
    data_b = 16'hFFFF; tick(); we_b = 1'b0;
    chk("b_ovf_count", count_b, 16);
    chk("b_ovf", ovf_b, EXP_ERR);
    for (int k = 0; k < 64; k++) begin
      w16 = bword(k / 4) >> (4 * (k % 4));
      chk($sformatf("b_drain%0d_q", k), q_b, w16[3:0]);
      re_b = 1'b1; tick();
    end
    re_b = 1'b0;
    chk("b_drained_empty", empty_b, 1);
    chk("b_drained_count", count_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
